tx_frame_scheduler: RTL and testbench



---
 rtl/tx_frame_scheduler.sv | 132 +++++++++++++
 tb/tb_tx_frame_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: round-robin TX frame arbiter with inter-frame gap and watchdog.
// Ports: aclk/areset (sync, active-high); req[NUM_REQ] level requests; grant one-hot owner;
// req_ack pulse on completion; tx_start pulse to preamble/SFD gen; tx_frame_done from TX mux;
// tx_busy high outside IDLE; timeout_err pulse on watchdog abort.
// Define TX_SCHED_STATS_EN to add saturating frame_cnt[31:0] and timeout_cnt[15:0].
module tx_frame_scheduler #(
   parameter int NUM_REQ        = 2,
   parameter int IFG_CYCLES     = 12,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] req_ack,
   output logic               tx_start,
   input  logic               tx_frame_done,
   output logic               tx_busy,
`ifdef TX_SCHED_STATS_EN
   output logic               timeout_err,
   output logic [31:0]        frame_cnt,
   output logic [15:0]        timeout_cnt
`else
   output logic               timeout_err
`endif
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam int CW = $clog2(IFG_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, START, ACTIVE, IFG} state_t;
   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d, req_ack_q, req_ack_d;
   logic               tx_start_q, tx_start_d, tx_busy_q, tx_busy_d, timeout_err_q, timeout_err_d;
   logic [IW-1:0]      ptr_q, ptr_d, owner_q, owner_d, win, ptr_nxt;
   logic [WW-1:0]      wd_q, wd_d;
   logic [CW-1:0]      ifg_q, ifg_d;
   // Descending scan so the requester closest to ptr (ascending, wrapping) wins.
   always_comb begin
      logic [IW-1:0] j;
      j   = '0;
      win = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = IW'((int'(ptr_q) + k) % NUM_REQ);
         if (req[j]) win = j;
      end
   end
   assign ptr_nxt = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      req_ack_d     = '0;
      tx_start_d    = 1'b0;
      timeout_err_d = 1'b0;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      wd_d          = wd_q;
      ifg_d         = ifg_q;
      case (state_q)
         IDLE: if (|req) begin
            state_d = START;
            grant_d = NUM_REQ'(1) << win;
            owner_d = win;
         end
         START: begin
            state_d    = ACTIVE;
            tx_start_d = 1'b1;
            wd_d       = '0;
         end
         ACTIVE: if (tx_frame_done || wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
            // done takes priority over a coincident watchdog expiry
            req_ack_d     = tx_frame_done ? grant_q : '0;
            timeout_err_d = !tx_frame_done;
            grant_d       = '0;
            ifg_d         = CW'(IFG_CYCLES - 1);
            ptr_d         = ptr_nxt;
            state_d       = IFG;
         end else wd_d = wd_q + WW'(1);
         IFG: if (ifg_q == '0) state_d = IDLE;
              else ifg_d = ifg_q - CW'(1);
      endcase
      tx_busy_d = state_d != IDLE;
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         req_ack_q     <= '0;
         tx_start_q    <= 1'b0;
         tx_busy_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         ptr_q         <= '0;
         owner_q       <= '0;
         wd_q          <= '0;
         ifg_q         <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         req_ack_q     <= req_ack_d;
         tx_start_q    <= tx_start_d;
         tx_busy_q     <= tx_busy_d;
         timeout_err_q <= timeout_err_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         wd_q          <= wd_d;
         ifg_q         <= ifg_d;
      end
   end
   assign grant       = grant_q;
   assign req_ack     = req_ack_q;
   assign tx_start    = tx_start_q;
   assign tx_busy     = tx_busy_q;
   assign timeout_err = timeout_err_q;
`ifdef TX_SCHED_STATS_EN
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] timeout_cnt_q, timeout_cnt_d;
   always_comb begin
      frame_cnt_d   = (|req_ack_d && !(&frame_cnt_q)) ? frame_cnt_q + 32'd1 : frame_cnt_q;
      timeout_cnt_d = (timeout_err_d && !(&timeout_cnt_q)) ? timeout_cnt_q + 16'd1 : timeout_cnt_q;
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         frame_cnt_q   <= '0;
         timeout_cnt_q <= '0;
      end else begin
         frame_cnt_q   <= frame_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end
   assign frame_cnt   = frame_cnt_q;
   assign timeout_cnt = timeout_cnt_q;
`endif
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: table, directed and randomized checks of tx_frame_scheduler.
module tb_tx_frame_scheduler;
   localparam int N = 2, IFG = 12, TO = 16;
   logic       aclk = 1'b0, areset = 1'b1, tx_frame_done = 1'b0;
   logic [1:0] req = 2'b00, grant, req_ack;
   logic       tx_start, tx_busy, timeout_err;
`ifdef TX_SCHED_STATS_EN
   logic [31:0] frame_cnt;
   logic [15:0] timeout_cnt;
`endif
   int vectors = 0, miscompares = 0, cyc = 0;
   bit m_valid = 0, m_ek = 0, m_bd = 0;
   int m_own = 0, m_g = 0, m_s = 0, m_e = 0, m_ptr = 0;
   typedef struct {
      logic [1:0] req;
      logic       done;
      logic [1:0] grant, ack;
      logic       start, busy, err;
   } vec_t;
   vec_t tbl[6];
   tx_frame_scheduler #(.NUM_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)) dut (
      .aclk(aclk), .areset(areset), .req(req), .grant(grant), .req_ack(req_ack),
      .tx_start(tx_start), .tx_frame_done(tx_frame_done), .tx_busy(tx_busy),
`ifdef TX_SCHED_STATS_EN
      .timeout_err(timeout_err), .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt)
`else
      .timeout_err(timeout_err)
`endif
   );
   always #5 aclk = ~aclk;
   function automatic logic [1:0] oh(int i);
      return 2'(1 << i);
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask
   // Frame timeline model: each frame is a set of timestamps (grant, start, end).
   task automatic model_update(logic [1:0] r, logic d, logic rst);
      if (rst) begin
         m_valid = 0;
         m_ptr   = 0;
         return;
      end
      if (m_valid && !m_ek && cyc >= m_s) begin
         if (d || cyc == m_s + TO - 1) begin
            m_e   = cyc + 1;
            m_ek  = 1;
            m_bd  = d;
            m_ptr = (m_own + 1) % N;
         end
      end else if ((!m_valid || (m_ek && cyc >= m_e + IFG)) && r != 2'b00) begin
         for (int k = N - 1; k >= 0; k--) if (r[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
         m_valid = 1;
         m_ek    = 0;
         m_g     = cyc + 1;
         m_s     = cyc + 2;
      end
   endtask
   task automatic model_check();
      logic [1:0] eg, ea;
      logic       es, eb, ee;
      eg = (m_valid && cyc >= m_g && (!m_ek || cyc < m_e)) ? oh(m_own) : 2'b00;
      ea = (m_valid && m_ek && cyc == m_e && m_bd) ? oh(m_own) : 2'b00;
      ee = m_valid && m_ek && cyc == m_e && !m_bd;
      es = m_valid && cyc == m_s;
      eb = m_valid && cyc >= m_g && (!m_ek || cyc < m_e + IFG);
      chk("model", {25'd0, grant, req_ack, tx_start, tx_busy, timeout_err}, {25'd0, eg, ea, es, eb, ee});
   endtask
   task automatic step(logic [1:0] r, logic d, logic rst);
      req           = r;
      tx_frame_done = d;
      areset        = rst;
      model_update(r, d, rst);
      @(posedge aclk);
      #1;
      cyc++;
      model_check();
   endtask
   initial begin
      logic [1:0] rr;
      tbl[0] = '{2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
      step(2'b00, 1'b0, 1'b1);
      step(2'b00, 1'b0, 1'b1);
      chk("reset_outs", {27'd0, grant, req_ack, tx_start, tx_busy, timeout_err}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         step(tbl[i].req, tbl[i].done, 1'b0);
         chk($sformatf("tbl%0d", i), {25'd0, grant, req_ack, tx_start, tx_busy, timeout_err},
             {25'd0, tbl[i].grant, tbl[i].ack, tbl[i].start, tbl[i].busy, tbl[i].err});
      end
      repeat (9) step(2'b00, 1'b0, 1'b0);
      chk("ifg_busy_last", tx_busy, 1);
      step(2'b00, 1'b0, 1'b0);
      chk("ifg_busy_low", tx_busy, 0);
      step(2'b10, 1'b0, 1'b0);
      chk("drop_grant", grant, 2'b10);
      step(2'b10, 1'b0, 1'b0);
      chk("drop_start", tx_start, 1);
      repeat (3) step(2'b00, 1'b0, 1'b0);
      chk("drop_hold", grant, 2'b10);
      step(2'b00, 1'b1, 1'b0);
      chk("drop_ack", {req_ack, grant}, 4'b1000);
      repeat (12) step(2'b00, 1'b0, 1'b0);
      chk("drop_idle", tx_busy, 0);
      for (int f = 0; f < 4; f++) begin
         step(2'b11, 1'b0, 1'b0);
         chk($sformatf("rr_grant%0d", f), grant, (f % 2) ? 2'b10 : 2'b01);
         step(2'b11, 1'b0, 1'b0);
         chk($sformatf("rr_start%0d", f), tx_start, 1);
         repeat (10) step(2'b11, 1'b0, 1'b0);
         step(2'b11, 1'b1, 1'b0);
         chk($sformatf("rr_ack%0d", f), req_ack, (f % 2) ? 2'b10 : 2'b01);
         repeat (12) step(2'b11, 1'b0, 1'b0);
      end
      step(2'b01, 1'b0, 1'b0);
      chk("wd_grant", grant, 2'b01);
      step(2'b01, 1'b0, 1'b0);
      chk("wd_start", tx_start, 1);
      repeat (15) step(2'b11, 1'b0, 1'b0);
      chk("wd_pre", {grant, timeout_err}, 3'b010);
      step(2'b11, 1'b0, 1'b0);
      chk("wd_fire", {grant, req_ack, tx_busy, timeout_err}, 6'b000011);
      repeat (12) step(2'b11, 1'b0, 1'b0);
      chk("wd_idle", tx_busy, 0);
      step(2'b11, 1'b0, 1'b0);
      chk("wd_next_grant", grant, 2'b10);
      step(2'b11, 1'b0, 1'b0);
      chk("co_start", tx_start, 1);
      repeat (15) step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b0);
      chk("co_ack_noerr", {req_ack, timeout_err}, 3'b100);
      repeat (12) step(2'b11, 1'b0, 1'b0);
      step(2'b01, 1'b0, 1'b0);
      chk("rs_grant0", grant, 2'b01);
      step(2'b01, 1'b0, 1'b0);
      step(2'b01, 1'b1, 1'b0);
      repeat (12) step(2'b00, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      chk("rs_grant1", grant, 2'b10);
      repeat (3) step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b1);
      chk("rs_outs", {27'd0, grant, req_ack, tx_start, tx_busy, timeout_err}, 32'd0);
`ifdef TX_SCHED_STATS_EN
      chk("rs_frame_cnt", frame_cnt, 0);
`endif
      step(2'b00, 1'b1, 1'b0);
      chk("rs_stray_done", {grant, req_ack, tx_busy}, 5'b0);
      step(2'b11, 1'b0, 1'b0);
      chk("rs_ptr0", grant, 2'b01);
      step(2'b00, 1'b0, 1'b1);
      rr = 2'b00;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < N; b++)
            rr[b] = rr[b] ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 3) == 0);
         step(rr, $urandom_range(0, 9) == 0, $urandom_range(0, 499) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
